// File: rtl/core_dispatch_controller_if.sv
// Bus between the dispatch controller and its ROM / core-set environment.
interface core_dispatch_controller_if #(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned TASK_W     = 26,
    parameter int unsigned ROM_ADDR_W = 16
);
    logic                          enable;
    logic [NUM_CORES-1:0]          taskReq;
    logic [ROM_ADDR_W-1:0]         romAddr;
    logic [7:0]                    romData;
    logic [NUM_CORES*TASK_W-1:0]   taskData;
    logic [NUM_CORES-1:0]          taskValid;
    logic [15:0]                   cycle;
    logic                          busy;
    logic                          tableEmpty;

    modport master (
        input  enable, taskReq, romData,
        output romAddr, taskData, taskValid, cycle, busy, tableEmpty
    );

    modport slave (
        output enable, taskReq, romData,
        input  romAddr, taskData, taskValid, cycle, busy, tableEmpty
    );
endinterface

// File: rtl/core_dispatch_controller.sv
// Round-robin task dispatcher: grants one requesting core, fetches the next
// big-endian task entry from a byte-wide ROM and delivers it to that core's slot.
module core_dispatch_controller #(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned TASK_W     = 26,
    parameter int unsigned ROM_ADDR_W = 16,
    parameter int unsigned START_ADDR = 0
) (
    input  logic                       fastClk,
    input  logic                       rstN,
    core_dispatch_controller_if.master bus
);
    localparam int unsigned NB     = (TASK_W + 7) / 8;
    localparam int unsigned BEAT_W = $clog2(NB + 1);
    localparam int unsigned IDX_W  = $clog2(NUM_CORES);
    localparam int unsigned DATA_W = NUM_CORES * TASK_W;
    localparam logic [ROM_ADDR_W-1:0] START = ROM_ADDR_W'(START_ADDR);

    typedef enum logic [2:0] {IDLE, READ, CAPT, CHECK, DELIVER} state_e;

    state_e                state_q, state_d;
    logic [ROM_ADDR_W-1:0] ptr_q, ptr_d;
    logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [TASK_W-1:0]     word_q, word_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [DATA_W-1:0]     task_data_q, task_data_d;
    logic [NUM_CORES-1:0]  task_valid_q, task_valid_d;
    logic [15:0]           cycle_q, cycle_d;
    logic                  busy_q, busy_d;
    logic                  empty_q, empty_d;
    logic                  wrapped_q, wrapped_d;

    logic                  rr_found;
    logic [IDX_W-1:0]      rr_idx;
    logic [IDX_W-1:0]      cand;

    // State and datapath registers
    always_ff @(posedge fastClk) begin
        if (!rstN) begin
            state_q      <= IDLE;
            ptr_q        <= START;
            rom_addr_q   <= START;
            beat_q       <= '0;
            word_q       <= '0;
            grant_q      <= '0;
            last_q       <= IDX_W'(NUM_CORES - 1);
            task_data_q  <= '0;
            task_valid_q <= '0;
            cycle_q      <= '0;
            busy_q       <= 1'b0;
            empty_q      <= 1'b0;
            wrapped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rom_addr_q   <= rom_addr_d;
            beat_q       <= beat_d;
            word_q       <= word_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            task_data_q  <= task_data_d;
            task_valid_q <= task_valid_d;
            cycle_q      <= cycle_d;
            busy_q       <= busy_d;
            empty_q      <= empty_d;
            wrapped_q    <= wrapped_d;
        end
    end

    // Next-state, fetch sequencing and round-robin selection
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        rom_addr_d   = rom_addr_q;
        beat_d       = beat_q;
        word_d       = word_q;
        grant_d      = grant_q;
        last_d       = last_q;
        task_data_d  = task_data_q;
        task_valid_d = '0;
        cycle_d      = cycle_q;
        empty_d      = empty_q;
        wrapped_d    = wrapped_q;
        rr_found     = 1'b0;
        rr_idx       = last_q;
        cand         = '0;

        for (int unsigned i = 1; i <= NUM_CORES; i++) begin
            cand = IDX_W'((32'(last_q) + i) % NUM_CORES);
            if (!rr_found && bus.taskReq[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.enable && rr_found) begin
                    grant_d    = rr_idx;
                    last_d     = rr_idx;
                    rom_addr_d = ptr_q;
                    beat_d     = '0;
                    state_d    = READ;
                end
            end
            READ: begin
                // ROM data lags the address by one cycle
                if (beat_q != '0) begin
                    word_d = TASK_W'({word_q, bus.romData});
                end
                if (beat_q == BEAT_W'(NB - 1)) begin
                    state_d = CAPT;
                end else begin
                    beat_d     = beat_q + BEAT_W'(1);
                    rom_addr_d = ptr_q + ROM_ADDR_W'(beat_q) + ROM_ADDR_W'(1);
                end
            end
            CAPT: begin
                word_d  = TASK_W'({word_q, bus.romData});
                state_d = CHECK;
            end
            CHECK: begin
                if (word_q == {TASK_W{1'b1}}) begin
                    if (wrapped_q) begin
                        // Marker right after a wrap: the table is empty
                        empty_d   = 1'b1;
                        wrapped_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        ptr_d      = START;
                        rom_addr_d = START;
                        cycle_d    = cycle_q + 16'd1;
                        wrapped_d  = 1'b1;
                        beat_d     = '0;
                        state_d    = READ;
                    end
                end else begin
                    task_data_d[32'(grant_q) * TASK_W +: TASK_W] = word_q;
                    task_valid_d[grant_q] = 1'b1;
                    wrapped_d = 1'b0;
                    state_d   = DELIVER;
                end
            end
            DELIVER: begin
                ptr_d   = ptr_q + ROM_ADDR_W'(NB);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.romAddr    = rom_addr_q;
    assign bus.taskData   = task_data_q;
    assign bus.taskValid  = task_valid_q;
    assign bus.cycle      = cycle_q;
    assign bus.busy       = busy_q;
    assign bus.tableEmpty = empty_q;

endmodule

// File: tb/tb_core_dispatch_controller.sv
// Directed bench for core_dispatch_controller: vector table plus
// hand-written sequences for round robin, enable, reset and empty table.
module tb_core_dispatch_controller;
    localparam int unsigned NC = 4;
    localparam int unsigned TW = 26;
    localparam int unsigned AW = 16;

    typedef struct {
        logic [NC-1:0] req;
        logic [NC-1:0] exp_valid;
        logic [TW-1:0] exp_word;
        int            exp_lat;
        logic [15:0]   exp_cycle;
        logic [AW-1:0] exp_addr;
    } vec_t;

    logic fastClk;
    logic rstN;
    logic [7:0]    rom [256];
    logic [TW-1:0] model [NC];
    vec_t          vecs [6];
    int            checks;
    int            errors;

    core_dispatch_controller_if #(.NUM_CORES(NC), .TASK_W(TW), .ROM_ADDR_W(AW)) bus ();

    core_dispatch_controller #(
        .NUM_CORES(NC), .TASK_W(TW), .ROM_ADDR_W(AW), .START_ADDR(0)
    ) dut (
        .fastClk(fastClk),
        .rstN   (rstN),
        .bus    (bus)
    );

    always #5 fastClk = ~fastClk;

    // Synchronous ROM: data appears one cycle after the address
    always @(posedge fastClk) bus.romData <= rom[bus.romAddr[7:0]];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NC*TW-1:0] packed_model();
        logic [NC*TW-1:0] r;
        for (int c = 0; c < NC; c++) r[c*TW +: TW] = model[c];
        return r;
    endfunction

    task automatic do_reset();
        @(negedge fastClk);
        rstN = 1'b0;
        bus.taskReq = '0;
        bus.enable  = 1'b1;
        @(posedge fastClk);
        @(posedge fastClk);
        @(negedge fastClk);
        rstN = 1'b1;
        for (int c = 0; c < NC; c++) model[c] = '0;
    endtask

    // One request, dropped after grant; checks latency, slice, counters, address
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        lat = 0;
        @(negedge fastClk);
        bus.taskReq = v.req;
        for (int n = 1; n <= 40; n++) begin
            @(posedge fastClk); #1;
            if (n == 1) bus.taskReq = '0;
            if (bus.taskValid != '0) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_lat"}, lat, v.exp_lat);
        chk({tag, "_valid"}, bus.taskValid, v.exp_valid);
        for (int c = 0; c < NC; c++) if (v.exp_valid[c]) model[c] = v.exp_word;
        chk({tag, "_data"}, bus.taskData, packed_model());
        chk({tag, "_cycle"}, bus.cycle, v.exp_cycle);
        @(posedge fastClk); #1;
        chk({tag, "_pulse"}, bus.taskValid, 0);
        chk({tag, "_addr"}, bus.romAddr, v.exp_addr);
        chk({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TW-1:0] rr_words [NC];
        vec_t  v;
        int    n_found;
        int    idle_n;
        logic  saw;
        logic  bad;

        checks = 0;
        errors = 0;
        fastClk = 1'b0;
        rstN = 1'b0;
        bus.enable = 1'b0;
        bus.taskReq = '0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        {rom[0],  rom[1],  rom[2],  rom[3]}  = 32'h0123_4567;
        {rom[4],  rom[5],  rom[6],  rom[7]}  = 32'h89AB_CDEF;
        {rom[8],  rom[9],  rom[10], rom[11]} = 32'h0000_002A;
        {rom[12], rom[13], rom[14], rom[15]} = 32'hFFFF_FFFE;
        {rom[16], rom[17], rom[18], rom[19]} = 32'hC3FF_FFFF;

        rr_words[0] = 26'h1234567;
        rr_words[1] = 26'h1ABCDEF;
        rr_words[2] = 26'h000002A;
        rr_words[3] = 26'h3FFFFFE;

        vecs[0] = '{4'b0001, 4'b0001, 26'h1234567,  7, 16'd0, 16'h0003};
        vecs[1] = '{4'b0100, 4'b0100, 26'h1ABCDEF,  7, 16'd0, 16'h0007};
        vecs[2] = '{4'b1001, 4'b1000, 26'h000002A,  7, 16'd0, 16'h000B};
        vecs[3] = '{4'b1001, 4'b0001, 26'h3FFFFFE,  7, 16'd0, 16'h000F};
        vecs[4] = '{4'b0010, 4'b0010, 26'h1234567, 13, 16'd1, 16'h0003};
        vecs[5] = '{4'b0110, 4'b0100, 26'h1ABCDEF,  7, 16'd1, 16'h0007};

        do_reset();
        chk("rst_busy",  bus.busy, 0);
        chk("rst_addr",  bus.romAddr, 0);
        chk("rst_valid", bus.taskValid, 0);
        chk("rst_data",  bus.taskData, 0);
        chk("rst_cycle", bus.cycle, 0);
        chk("rst_empty", bus.tableEmpty, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of READ byte 2 (ptr is 8 here)
        @(negedge fastClk);
        bus.taskReq = 4'b0001;
        @(posedge fastClk); #1;
        bus.taskReq = '0;
        @(posedge fastClk); #1;
        @(posedge fastClk); #1;
        chk("mid_rd_addr", bus.romAddr, 16'd10);
        @(negedge fastClk);
        rstN = 1'b0;
        @(posedge fastClk); #1;
        chk("mid_busy",  bus.busy, 0);
        chk("mid_addr",  bus.romAddr, 0);
        chk("mid_valid", bus.taskValid, 0);
        chk("mid_cycle", bus.cycle, 0);
        chk("mid_data",  bus.taskData, 0);
        @(negedge fastClk);
        rstN = 1'b1;
        for (int c = 0; c < NC; c++) model[c] = '0;
        v = '{4'b0001, 4'b0001, 26'h1234567, 7, 16'd0, 16'h0003};
        run_vec(v, "restart");

        // All cores requesting: grants 0,1,2,3 at fixed spacing
        do_reset();
        @(negedge fastClk);
        bus.taskReq = 4'b1111;
        for (int d = 0; d < NC; d++) begin
            n_found = 0;
            for (int n = 1; n <= 40; n++) begin
                @(posedge fastClk); #1;
                if (bus.taskValid != '0) begin
                    n_found = n;
                    break;
                end
            end
            chk($sformatf("rr%0d_gap", d), n_found, (d == 0) ? 7 : 8);
            chk($sformatf("rr%0d_valid", d), bus.taskValid, 4'b0001 << d);
            model[d] = rr_words[d];
            chk($sformatf("rr%0d_data", d), bus.taskData, packed_model());
        end
        bus.taskReq = '0;
        @(posedge fastClk); #1;
        chk("rr_idle", bus.busy, 0);
        chk("rr_addr", bus.romAddr, 16'h000F);
        @(posedge fastClk); #1;
        chk("rr_nogrant", bus.busy, 0);
        // ptr now 0x10: the marker there wraps back to entry 0
        v = '{4'b0001, 4'b0001, 26'h1234567, 13, 16'd1, 16'h0003};
        run_vec(v, "rr_wrap");

        // Enable low blocks grants; dropping it mid-fetch does not
        do_reset();
        @(negedge fastClk);
        bus.enable = 1'b0;
        bus.taskReq = 4'b0010;
        bad = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(posedge fastClk); #1;
            bad |= bus.busy;
        end
        chk("dis_busy", bad, 0);
        @(negedge fastClk);
        bus.enable = 1'b1;
        @(posedge fastClk); #1;
        chk("en_busy", bus.busy, 1);
        bus.enable = 1'b0;
        n_found = 0;
        for (int n = 2; n <= 40; n++) begin
            @(posedge fastClk); #1;
            if (bus.taskValid != '0) begin
                n_found = n;
                break;
            end
        end
        chk("en_lat", n_found, 7);
        chk("en_valid", bus.taskValid, 4'b0010);
        model[1] = 26'h1234567;
        chk("en_data", bus.taskData, packed_model());
        @(posedge fastClk); #1;
        @(posedge fastClk); #1;
        chk("en_hold_idle", bus.busy, 0);
        bus.taskReq = '0;
        bus.enable = 1'b1;

        // Empty table: marker at START_ADDR both before and after the wrap
        {rom[0], rom[1], rom[2], rom[3]} = 32'hFFFF_FFFF;
        do_reset();
        @(negedge fastClk);
        bus.taskReq = 4'b0001;
        saw = 1'b0;
        idle_n = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge fastClk); #1;
            if (n == 1) bus.taskReq = '0;
            if (bus.taskValid != '0) saw = 1'b1;
            if (!bus.busy) begin
                idle_n = n;
                break;
            end
        end
        chk("emp_novalid", saw, 0);
        chk("emp_lat", idle_n, 13);
        chk("emp_flag", bus.tableEmpty, 1);
        chk("emp_cycle", bus.cycle, 1);
        chk("emp_data", bus.taskData, 0);
        @(negedge fastClk);
        bus.taskReq = 4'b0010;
        @(posedge fastClk); #1;
        bus.taskReq = '0;
        chk("emp_rearb", bus.busy, 1);
        for (int n = 0; n < 40; n++) begin
            if (!bus.busy) break;
            @(posedge fastClk); #1;
        end
        chk("emp2_cycle", bus.cycle, 2);
        chk("emp2_flag", bus.tableEmpty, 1);
        do_reset();
        chk("emp_rst", bus.tableEmpty, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/core_dispatch_controller.md
CORE_DISPATCH_CONTROLLER -- requirements
Module: core_dispatch_controller

Interface
REQ-001 Parameter NUM_CORES, default 4; number of core sets served, range 2..16.
REQ-002 Parameter TASK_W, default 26; task word width, range 9..32.
REQ-003 Parameter ROM_ADDR_W, default 16; ROM byte address width.
REQ-004 Parameter START_ADDR, default 0; byte address of the first task table entry.
REQ-005 fastClk  input  1  the only clock; all logic on its rising edge.
REQ-006 rstN  input  1  reset, synchronous and active-low.
REQ-007 enable  input  1  when high, new dispatches may start.
REQ-008 taskReq  input  NUM_CORES  bit i high = core i requests a task.
REQ-009 romAddr  output  ROM_ADDR_W  ROM byte address, registered.
REQ-010 romData  input  8  ROM byte; valid one cycle after romAddr is presented.
REQ-011 taskData  output  NUM_CORES*TASK_W  per-core task register; slice i = bits [i*TASK_W +: TASK_W].
REQ-012 taskValid  output  NUM_CORES  one-cycle pulse; bit i = slice i was just updated.
REQ-013 cycle  output  16  table pass counter.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 tableEmpty  output  1  sticky flag: table holds no tasks.

Function
REQ-016 NB = ceil(TASK_W/8) bytes per entry, stored big-endian; the task word is the low TASK_W bits of the assembled NB*8-bit value.
REQ-017 End marker = task word of all ones (TASK_W bits).
REQ-018 FSM states: IDLE, READ, CAPT, CHECK, DELIVER.
REQ-019 IDLE: if enable and taskReq != 0, grant one core via round robin, go to READ; otherwise stay.
REQ-020 Round robin: search starts at the index after the last granted core, wrapping at NUM_CORES; after reset, core 0 has highest priority.
REQ-021 READ: lasts NB cycles; in cycle k, romAddr = ptr + k (modulo 2^ROM_ADDR_W); byte k-1 is captured from romData in cycle k (k >= 1).
REQ-022 CAPT: one cycle; captures byte NB-1.
REQ-023 CHECK, non-marker word: go to DELIVER.
REQ-024 CHECK, end marker: ptr <= START_ADDR, cycle <= cycle + 1 (wrap 16'hFFFF -> 0), return to READ for the same grantee.
REQ-025 Empty table: if the marker is found at START_ADDR immediately after a wrap, set tableEmpty, deliver nothing, return to IDLE, and do not increment cycle a second time.
REQ-026 DELIVER: taskData slice of the grantee <= word; taskValid[grantee] = 1 for exactly this cycle; ptr <= ptr + NB (modulo 2^ROM_ADDR_W); go to IDLE.
REQ-027 Latency: request sampled in IDLE at cycle T -> taskValid high at cycle T+NB+3, provided no marker is met.
REQ-028 A grant is never revoked; if the grantee drops taskReq mid-fetch, the fetch still completes, delivers, and advances ptr.
REQ-029 enable low only blocks new grants in IDLE; a fetch in progress always completes.
REQ-030 At most one taskValid bit is high in any cycle; other slices of taskData hold their values.
REQ-031 tableEmpty is cleared only by reset; requests continue to be arbitrated while it is set.
REQ-032 romAddr holds its last value in IDLE.

Reset
REQ-033 While rstN is low at a rising edge, the following apply, including mid-fetch, where the partial word is discarded: state = IDLE; ptr = romAddr = START_ADDR; taskData = 0; taskValid = 0; cycle = 0; busy = 0; tableEmpty = 0; round-robin pointer set so core 0 has priority.

Verification
REQ-034 NUM_CORES=4, TASK_W=26, ROM[0..3] = 8'h01,8'h23,8'h45,8'h67; taskReq=4'b0001 at T -> taskValid=4'b0001 at T+7, slice 0 = 26'h1234567, romAddr ends at 16'h0003, next ptr = 16'h0004.
REQ-035 taskReq=4'b1111 held with four valid entries -> grants in order cores 0,1,2,3, each delivery 7 cycles after the previous return to IDLE, ptr = 16'h0010 at the end.
REQ-036 Entry at 16'h0004 = 8'hFF x4 (marker) -> cycle goes 0 -> 1, core re-receives entry 0 (26'h1234567); latency = T+13.
REQ-037 ROM[0..3] = marker -> tableEmpty=1, no taskValid pulse, cycle=1, FSM returns to IDLE.
REQ-038 rstN low during READ byte 2 -> next cycle busy=0, romAddr=16'h0000, taskValid=0, cycle=0; a new request restarts from START_ADDR.
REQ-039 enable low with taskReq=4'b0010 -> busy stays 0; enable dropped mid-fetch -> that delivery still occurs.
